// File: rtl/block_interleaver.sv
// block_interleaver
// Ping-pong ROWS x COLS block interleaver / deinterleaver.
// Symbols are written row-major into one bank. The previously completed bank
// is read out in permuted order, one symbol per accepted input, so output
// runs in lock-step with input once the first block has been written.
// Optional feature macro: INTLV_SOF_EN adds sof_i / align_err_o
// (input block re-alignment with a sticky error flag).

module block_interleaver #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_i,
`ifdef INTLV_SOF_EN
  input  logic              sof_i,
  output logic              align_err_o,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] data_o,
  output logic              frame_start_o
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] IDX_FIRST = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_LAST  = AW'(N - 1);

  // Permuted read address for output position r of a completed block.
  // Interleave reads column-major what was written row-major; deinterleave
  // swaps the roles of ROWS and COLS so it exactly undoes the interleave.
  function automatic logic [AW-1:0] perm_addr(input logic [AW-1:0] r, input logic mode);
    int ri;
    int a;
    ri = 32'(r);
    if (mode == 1'b0) begin
      a = (ri % ROWS) * COLS + (ri / ROWS);
    end else begin
      a = (ri % COLS) * ROWS + (ri / COLS);
    end
    return a[AW-1:0];
  endfunction

  // Two symbol banks; contents are don't-care until a full block is written.
  logic [DATA_W-1:0] mem_r [2][N];

  logic [AW-1:0] w_r;        // write index inside the current bank
  logic          wb_r;       // bank currently being written
  logic [1:0]    full_r;     // per-bank "holds a complete block"
  logic [1:0]    bmode_r;    // per-bank mode latched at its first symbol

  logic          misalign_s; // start-of-block marker seen mid-block
  logic [AW-1:0] wr_idx_s;   // index this accepted symbol is written to
  logic          rd_bank_s;  // bank being read out
  logic [AW-1:0] rd_addr_s;  // permuted read address in the read bank
  logic          emit_s;     // read bank holds a block worth emitting

  // Resolve write index, read bank/address and whether this symbol emits.
  always_comb begin
    misalign_s = 1'b0;
`ifdef INTLV_SOF_EN
    if (sof_i && (w_r != IDX_FIRST)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
`endif
    if (misalign_s) begin
      wr_idx_s = IDX_FIRST;
    end else begin
      wr_idx_s = w_r;
    end
    rd_bank_s = ~wb_r;
    rd_addr_s = perm_addr(wr_idx_s, bmode_r[rd_bank_s]);
    emit_s    = full_r[rd_bank_s] & ~misalign_s;
  end

  // Store each accepted symbol into the bank being written (no reset needed).
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_r[wb_r][wr_idx_s] <= data_i;
    end
  end

  // Write-index / bank-swap control and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_r           <= IDX_FIRST;
      wb_r          <= 1'b0;
      full_r        <= 2'b00;
      bmode_r       <= 2'b00;
      out_valid     <= 1'b0;
      frame_start_o <= 1'b0;
      data_o        <= {DATA_W{1'b0}};
`ifdef INTLV_SOF_EN
      align_err_o   <= 1'b0;
`endif
    end else if (in_valid) begin
      if (wr_idx_s == IDX_FIRST) begin
        bmode_r[wb_r] <= mode_i;
      end

      if (emit_s) begin
        data_o        <= mem_r[rd_bank_s][rd_addr_s];
        out_valid     <= 1'b1;
        frame_start_o <= (wr_idx_s == IDX_FIRST);
      end else begin
        out_valid     <= 1'b0;
        frame_start_o <= 1'b0;
      end

      // A mid-block marker abandons the partial block and the stale read
      // bank, so output only resumes after a fresh complete block.
      if (misalign_s) begin
        full_r[rd_bank_s] <= 1'b0;
`ifdef INTLV_SOF_EN
        align_err_o       <= 1'b1;
`endif
      end

      if (wr_idx_s == IDX_LAST) begin
        w_r          <= IDX_FIRST;
        full_r[wb_r] <= 1'b1;
        wb_r         <= ~wb_r;
      end else begin
        w_r          <= wr_idx_s + {{(AW-1){1'b0}}, 1'b1};
      end
    end else begin
      out_valid     <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule
